// File: rtl/video_timing_pkg.sv
// Shared timing types, standard CEA mode constants and the line/frame total helper
// for the raster timing generator.
package video_timing_pkg;

    localparam int VT_CW = 12;

    // Field slots of the packed config vector used inside the generator.
    localparam int F_HA  = 0;
    localparam int F_HFP = 1;
    localparam int F_HS  = 2;
    localparam int F_HBP = 3;
    localparam int F_VA  = 4;
    localparam int F_VFP = 5;
    localparam int F_VS  = 6;
    localparam int F_VBP = 7;
    localparam int NF    = 8;

    typedef struct packed {
        logic [VT_CW-1:0] h_active;
        logic [VT_CW-1:0] h_fp;
        logic [VT_CW-1:0] h_sync;
        logic [VT_CW-1:0] h_bp;
        logic [VT_CW-1:0] v_active;
        logic [VT_CW-1:0] v_fp;
        logic [VT_CW-1:0] v_sync;
        logic [VT_CW-1:0] v_bp;
        logic             hs_pol;
        logic             vs_pol;
    } vt_cfg_t;

    localparam vt_cfg_t MODE_640X480P60 = '{h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2, v_bp: 12'd33, hs_pol: 1'b0, vs_pol: 1'b0};
    localparam vt_cfg_t MODE_720X480P60 = '{h_active: 12'd720, h_fp: 12'd16, h_sync: 12'd62, h_bp: 12'd60,
        v_active: 12'd480, v_fp: 12'd9, v_sync: 12'd6, v_bp: 12'd30, hs_pol: 1'b0, vs_pol: 1'b0};
    localparam vt_cfg_t MODE_1280X720P60 = '{h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
        v_active: 12'd720, v_fp: 12'd5, v_sync: 12'd5, v_bp: 12'd20, hs_pol: 1'b1, vs_pol: 1'b1};
    localparam vt_cfg_t MODE_1920X1080P60 = '{h_active: 12'd1920, h_fp: 12'd88, h_sync: 12'd44, h_bp: 12'd148,
        v_active: 12'd1080, v_fp: 12'd4, v_sync: 12'd5, v_bp: 12'd36, hs_pol: 1'b1, vs_pol: 1'b1};

    function automatic int unsigned vt_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_axis.sv
// One raster axis: position counter with wrap detect plus active/sync window decode.
module vtg_axis #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_adv,
    input  logic [CW-1:0] i_active,
    input  logic [CW-1:0] i_fp,
    input  logic [CW-1:0] i_sync,
    input  logic [CW+1:0] i_total,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap,
    output logic          o_act,
    output logic          o_sync
);
    localparam logic [CW+1:0] ONE = (CW+2)'(1);

    logic [CW-1:0] r_cnt;
    logic [CW+1:0] w_cnt_x, w_sync_lo, w_sync_hi;

    assign w_cnt_x   = {2'b00, r_cnt};
    assign w_sync_lo = {2'b00, i_active} + {2'b00, i_fp};
    assign w_sync_hi = w_sync_lo + {2'b00, i_sync};

    assign o_cnt  = r_cnt;
    assign o_wrap = i_adv && (w_cnt_x == i_total - ONE);
    assign o_act  = r_cnt < i_active;
    assign o_sync = (w_cnt_x >= w_sync_lo) && (w_cnt_x < w_sync_hi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (!i_en)
            r_cnt <= '0;
        else if (i_adv)
            r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: shadowed config applied on frame boundaries,
// registered DE/HS/VS, active coordinates and frame markers.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW           = 12,
    parameter int FCW          = 16,
    parameter int DEF_H_ACTIVE = 1280,
    parameter int DEF_H_FP     = 110,
    parameter int DEF_H_SYNC   = 40,
    parameter int DEF_H_BP     = 220,
    parameter int DEF_V_ACTIVE = 720,
    parameter int DEF_V_FP     = 5,
    parameter int DEF_V_SYNC   = 5,
    parameter int DEF_V_BP     = 20,
    parameter bit DEF_HS_POL   = 1'b1,
    parameter bit DEF_VS_POL   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_load,
    input  logic [CW-1:0]  cfg_h_active,
    input  logic [CW-1:0]  cfg_h_fp,
    input  logic [CW-1:0]  cfg_h_sync,
    input  logic [CW-1:0]  cfg_h_bp,
    input  logic [CW-1:0]  cfg_v_active,
    input  logic [CW-1:0]  cfg_v_fp,
    input  logic [CW-1:0]  cfg_v_sync,
    input  logic [CW-1:0]  cfg_v_bp,
    input  logic           cfg_hs_pol,
    input  logic           cfg_vs_pol,
    output logic           cfg_pending,
    output logic           cfg_applied,
    output logic           cfg_err,
    output logic           de,
    output logic           hs,
    output logic           vs,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           sof,
    output logic           eol,
    output logic [FCW-1:0] frame_cnt
);
    localparam logic [NF-1:0][CW-1:0] DEF_CFG = {CW'(DEF_V_BP), CW'(DEF_V_SYNC), CW'(DEF_V_FP),
        CW'(DEF_V_ACTIVE), CW'(DEF_H_BP), CW'(DEF_H_SYNC), CW'(DEF_H_FP), CW'(DEF_H_ACTIVE)};
    localparam logic [CW+1:0] TOT_MAX = (CW+2)'(2**CW);

    logic [NF-1:0][CW-1:0] r_live, r_pend, w_cfg_in;
    logic r_hpol, r_vpol, r_pend_hpol, r_pend_vpol;
    logic r_pending, r_applied, r_err;
    logic r_de, r_hs, r_vs, r_sof, r_eol;
    logic [CW-1:0]  r_x, r_y;
    logic [FCW-1:0] r_fcnt;

    logic [CW+1:0] w_h_total, w_v_total, w_ld_htot, w_ld_vtot;
    logic [CW-1:0] w_hcnt, w_vcnt;
    logic w_hwrap, w_vwrap, w_hact, w_vact, w_hsync, w_vsync;
    logic w_ld_bad, w_ld_ok, w_apply, w_de_n;

    assign w_cfg_in = {cfg_v_bp, cfg_v_sync, cfg_v_fp, cfg_v_active,
                       cfg_h_bp, cfg_h_sync, cfg_h_fp, cfg_h_active};

    assign w_h_total = (CW+2)'(vt_total(32'(r_live[F_HA]), 32'(r_live[F_HFP]),
                                        32'(r_live[F_HS]), 32'(r_live[F_HBP])));
    assign w_v_total = (CW+2)'(vt_total(32'(r_live[F_VA]), 32'(r_live[F_VFP]),
                                        32'(r_live[F_VS]), 32'(r_live[F_VBP])));
    assign w_ld_htot = (CW+2)'(vt_total(32'(w_cfg_in[F_HA]), 32'(w_cfg_in[F_HFP]),
                                        32'(w_cfg_in[F_HS]), 32'(w_cfg_in[F_HBP])));
    assign w_ld_vtot = (CW+2)'(vt_total(32'(w_cfg_in[F_VA]), 32'(w_cfg_in[F_VFP]),
                                        32'(w_cfg_in[F_VS]), 32'(w_cfg_in[F_VBP])));

    assign w_ld_bad = (w_cfg_in[F_HA] == '0) || (w_cfg_in[F_VA] == '0) ||
                      (w_cfg_in[F_HS] == '0) || (w_cfg_in[F_VS] == '0) ||
                      (w_ld_htot > TOT_MAX)  || (w_ld_vtot > TOT_MAX);
    assign w_ld_ok  = cfg_load && !w_ld_bad;
    // While stopped the counters sit at 0, so a pending config can go live at once.
    assign w_apply  = r_pending && (en ? (w_hwrap && w_vwrap) : 1'b1);

    vtg_axis #(.CW(CW)) u_h (
        .clk(clk), .rst(rst), .i_en(en), .i_adv(en),
        .i_active(r_live[F_HA]), .i_fp(r_live[F_HFP]), .i_sync(r_live[F_HS]), .i_total(w_h_total),
        .o_cnt(w_hcnt), .o_wrap(w_hwrap), .o_act(w_hact), .o_sync(w_hsync)
    );

    vtg_axis #(.CW(CW)) u_v (
        .clk(clk), .rst(rst), .i_en(en), .i_adv(w_hwrap),
        .i_active(r_live[F_VA]), .i_fp(r_live[F_VFP]), .i_sync(r_live[F_VS]), .i_total(w_v_total),
        .o_cnt(w_vcnt), .o_wrap(w_vwrap), .o_act(w_vact), .o_sync(w_vsync)
    );

    assign w_de_n = en && w_hact && w_vact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live      <= DEF_CFG;
            r_hpol      <= DEF_HS_POL;
            r_vpol      <= DEF_VS_POL;
            r_pend      <= '0;
            r_pend_hpol <= 1'b0;
            r_pend_vpol <= 1'b0;
            r_pending   <= 1'b0;
            r_applied   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_applied <= w_apply;
            r_err     <= cfg_load && w_ld_bad;
            if (w_apply) begin
                r_live <= r_pend;
                r_hpol <= r_pend_hpol;
                r_vpol <= r_pend_vpol;
            end
            if (w_ld_ok) begin
                r_pend      <= w_cfg_in;
                r_pend_hpol <= cfg_hs_pol;
                r_pend_vpol <= cfg_vs_pol;
            end
            r_pending <= w_ld_ok || (r_pending && !w_apply);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de   <= 1'b0;
            r_hs   <= ~DEF_HS_POL;
            r_vs   <= ~DEF_VS_POL;
            r_x    <= '0;
            r_y    <= '0;
            r_sof  <= 1'b0;
            r_eol  <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_de  <= w_de_n;
            r_hs  <= (en && w_hsync) ? r_hpol : ~r_hpol;
            r_vs  <= (en && w_vsync) ? r_vpol : ~r_vpol;
            r_x   <= w_de_n ? w_hcnt : '0;
            r_y   <= w_de_n ? w_vcnt : '0;
            r_sof <= en && (w_hcnt == '0) && (w_vcnt == '0);
            r_eol <= w_de_n && (w_hcnt == r_live[F_HA] - CW'(1));
            if (w_hwrap && w_vwrap)
                r_fcnt <= r_fcnt + FCW'(1);
        end
    end

    assign cfg_pending = r_pending;
    assign cfg_applied = r_applied;
    assign cfg_err     = r_err;
    assign de          = r_de;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign x           = r_x;
    assign y           = r_y;
    assign sof         = r_sof;
    assign eol         = r_eol;
    assign frame_cnt   = r_fcnt;

endmodule
